// File: rtl/id_hazard_controller_pkg.sv
// Shared types for the ID-stage hazard controller: FSM state encoding.
package id_hazard_controller_pkg;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_DIV_BUSY = 1'b1
   } hz_state_e;

endpackage

// File: rtl/id_hazard_controller_load_use_detect.sv
// Combinational load-use comparator: flags an ID operand that needs the
// result of a load still sitting in EX.
module id_hazard_controller_load_use_detect (
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_rs1_used_i,
   input  logic       id_rs2_used_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_mem_read_i,
   output logic       hazard_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_i);
   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign hazard_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_hazard_controller.sv
// Pipeline hold/flush sequencer for the 5-stage RV32IM core: load-use stalls,
// taken-branch flushes, multi-cycle divide occupancy and a stall counter.
module id_hazard_controller
   import id_hazard_controller_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_is_div,
   input  logic        branch_taken,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        if_id_flush,
   output logic        id_ex_we,
   output logic        id_ex_bubble,
   output logic        ex_mem_bubble,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] stall_cycles
);

   // A single-cycle divide completes inside the normal EX slot and needs no hold
   localparam bit               DIV_EN   = (DIV_CYCLES >= 2);
   localparam logic [CNT_W-1:0] CNT_INIT = DIV_EN ? CNT_W'(DIV_CYCLES - 2) : '0;

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      stall_q, stall_d;
   logic             load_use;

   id_hazard_controller_load_use_detect u_load_use_detect (
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_rs1_used_i (id_rs1_used),
      .id_rs2_used_i (id_rs2_used),
      .ex_rd_i       (ex_rd),
      .ex_mem_read_i (ex_mem_read),
      .hazard_o      (load_use)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_we         = 1'b1;
      if_id_we      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_we      = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      div_busy      = 1'b0;
      div_done      = 1'b0;

      if (RESET) begin
         pc_we         = 1'b0;
         if_id_we      = 1'b0;
         id_ex_we      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b1;
      end else if (state_q == HZ_DIV_BUSY) begin
         if (cnt_q != '0) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            div_busy      = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
         end else begin
            // Release: the divide leaves EX now; its still-high ex_is_div is ignored
            div_done = 1'b1;
            state_d  = HZ_RUN;
         end
      end else if (DIV_EN && ex_is_div) begin
         pc_we         = 1'b0;
         if_id_we      = 1'b0;
         id_ex_we      = 1'b0;
         ex_mem_bubble = 1'b1;
         div_busy      = 1'b1;
         cnt_d         = CNT_INIT;
         state_d       = HZ_DIV_BUSY;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   assign stall_d      = stall_q + {31'd0, ~pc_we};
   assign stall_cycles = stall_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= HZ_RUN;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

endmodule
